// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state/op encodings and latency constants for multdiv_seq
package multdiv_pkg;
    typedef enum logic [2:0] {IDLE, MUL, MFIN, DPRE, DIV, DFIX, DONE} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_e;
    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 34;
endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: start/operand/result bundle of multdiv_seq
//   master drives ctrl_MULT, ctrl_DIV, data_operandA/B; slave drives data_result,
//   data_exception, data_resultRDY
interface multdiv_if #(parameter int WIDTH = 32);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    modport master (output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                    input data_result, data_exception, data_resultRDY);
    modport slave (input ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                   output data_result, data_exception, data_resultRDY);
endinterface

// File: rtl/cla_32.sv
// cla_32: WIDTH-bit adder from WIDTH/8 cla_8 slices with second-level lookahead
//   a, b, cin in; sum, cout out
module cla_32 #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N = WIDTH / 8;
    logic [N-1:0] pg, gg, c;
    logic         cc;
    always_comb begin
        cc = cin;
        for (int k = 0; k < N; k++) begin
            c[k] = cc;
            cc   = gg[k] | (pg[k] & cc);
        end
        cout = cc;
    end
    for (genvar j = 0; j < N; j++) begin : g_slice
        cla_8 u_cla8 (.a(a[8*j+:8]), .b(b[8*j+:8]), .cin(c[j]), .s(sum[8*j+:8]), .pg(pg[j]), .gg(gg[j]));
    end
endmodule

// File: rtl/cla_8.sv
// cla_8: 8-bit carry-lookahead slice
//   a, b, cin in; s sum out; pg/gg group propagate/generate for the next lookahead level
module cla_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       pg,
    output logic       gg
);
    logic [7:0] p, g;
    logic       cc;
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        cc = cin;
        gg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i] = p[i] ^ cc;
            cc   = g[i] | (p[i] & cc);
            gg   = g[i] | (p[i] & gg);
        end
        pg = &p;
    end
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed Booth multiplier / restoring divider on one shared CLA
//   clock, reset_n (async active-low); bus: multdiv_if.slave (start pulses, operands,
//   result, exception, one-cycle resultRDY). Divider present only with MULTDIV_DIV_EN.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clock,
    input logic      reset_n,
    multdiv_if.slave bus
);
    localparam logic [5:0] LAST = 6'(WIDTH - 1);
    state_e           state_q, state_d;
    booth_op_e        op;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, a_q, a_d, res_q, res_d;
    logic [WIDTH-1:0] x, y, sum;
    logic [5:0]       cnt_q, cnt_d;
    logic             q_q, q_d, exc_q, exc_d, rdy_q, rdy_d, cin, cout, sgn;
`ifdef MULTDIV_DIV_EN
    logic             sign_q, sign_d;
`endif
    // DIV feeds the shifted remainder minus divisor; otherwise the Booth add/sub/pass
    always_comb begin
        op  = {p_lo_q[0], q_q} == 2'b01 ? OP_ADD : {p_lo_q[0], q_q} == 2'b10 ? OP_SUB : OP_NOP;
        x   = state_q == DIV ? {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]} : p_hi_q;
        y   = (state_q == DIV || op == OP_SUB) ? ~a_q : op == OP_ADD ? a_q : '0;
        cin = state_q == DIV || op == OP_SUB;
        // true sign of the (WIDTH+1)-bit sum, so a -2^(WIDTH-1) operand shifts correctly
        sgn = x[WIDTH-1] ^ y[WIDTH-1] ^ cout;
    end
    cla_32 #(.WIDTH(WIDTH)) u_cla (.a(x), .b(y), .cin(cin), .sum(sum), .cout(cout));
    always_comb begin
        state_d = state_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        q_d     = q_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
`ifdef MULTDIV_DIV_EN
        sign_d  = sign_q;
`endif
        if (bus.ctrl_MULT) begin
            state_d = MUL;
            p_hi_d  = '0;
            p_lo_d  = bus.data_operandB;
            q_d     = 1'b0;
            a_d     = bus.data_operandA;
            cnt_d   = '0;
        end else if (bus.ctrl_DIV) begin
            // rejected divides finish through MFIN with a product that reads as
            // result 0 plus overflow, so the flags land one edge later
            state_d = MFIN;
            p_hi_d  = '1;
            p_lo_d  = '0;
`ifdef MULTDIV_DIV_EN
            if (bus.data_operandB != '0) begin
                state_d = DPRE;
                p_lo_d  = bus.data_operandA;
                a_d     = bus.data_operandB;
                cnt_d   = '0;
            end
`endif
        end else begin
            case (state_q)
                MUL: begin
                    p_hi_d  = {sgn, sum[WIDTH-1:1]};
                    p_lo_d  = {sum[0], p_lo_q[WIDTH-1:1]};
                    q_d     = p_lo_q[0];
                    cnt_d   = cnt_q + 6'd1;
                    state_d = cnt_q == LAST ? MFIN : MUL;
                end
                MFIN: begin
                    res_d   = p_lo_q;
                    exc_d   = p_hi_q != {WIDTH{p_lo_q[WIDTH-1]}};
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
`ifdef MULTDIV_DIV_EN
                DPRE: begin
                    p_hi_d  = '0;
                    p_lo_d  = p_lo_q[WIDTH-1] ? -p_lo_q : p_lo_q;
                    a_d     = a_q[WIDTH-1] ? -a_q : a_q;
                    sign_d  = p_lo_q[WIDTH-1] ^ a_q[WIDTH-1];
                    state_d = DIV;
                end
                DIV: begin
                    p_hi_d  = cout ? sum : x;
                    p_lo_d  = {p_lo_q[WIDTH-2:0], cout};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = cnt_q == LAST ? DFIX : DIV;
                end
                DFIX: begin
                    res_d   = sign_q ? -p_lo_q : p_lo_q;
                    // a positive quotient of 2^(WIDTH-1) only arises from MIN / -1
                    exc_d   = !sign_q && p_lo_q[WIDTH-1];
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            q_q     <= 1'b0;
            a_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            q_q     <= q_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end
`ifdef MULTDIV_DIV_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sign_q <= 1'b0;
        else sign_q <= sign_d;
    end
`endif
    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Sequential signed 32-bit multiply/divide unit that sits directly downstream of the carry-lookahead adder datapath in the CPU ALU. Each iteration cycle it feeds one add/subtract into a 32-bit CLA adder and registers the sum, building the result over a fixed number of cycles. It runs alongside the single-cycle ALU; the pipeline stalls on `data_resultRDY`.

## Interface
- `WIDTH`, 32: operand and result width. Must be a multiple of 8.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_MULT` in 1: one-cycle start pulse for a multiply.
- `ctrl_DIV` in 1: one-cycle start pulse for a divide.
- `data_operandA` in WIDTH: multiplicand or dividend, two's complement, sampled on the start edge.
- `data_operandB` in WIDTH: multiplier or divisor, two's complement, sampled on the start edge.
- `data_result` out WIDTH: low WIDTH bits of the product, or the quotient. Held until the next start.
- `data_exception` out 1: overflow or divide-by-zero. Valid while `data_resultRDY` is high and held afterwards.
- `data_resultRDY` out 1: one-cycle registered done pulse.

## Operation
- **States:**
  - IDLE → MUL on `ctrl_MULT`.
  - IDLE → DPRE on `ctrl_DIV`.
  - MUL (WIDTH cycles) → MFIN → DONE.
  - DPRE → DIV (WIDTH cycles) → DFIX → DONE.
  - DONE → IDLE.
- **Start handling:**
  - A start pulse in any state, including DONE, aborts the current operation and restarts with the new operands.
  - If both start pulses are high, `ctrl_MULT` wins.
- **Multiply:**
  - Radix-2 Booth over a 2·WIDTH+1 register {P_hi, P_lo, q-1}.
  - Each MUL cycle: the adder computes P_hi + A, P_hi − A (A inverted, Cin=1) or a pass-through, selected by {P_lo[0], q-1]. Then arithmetic shift right by one.
  - A 6-bit iteration counter terminates the loop.
  - MFIN: `data_exception` = 1 iff P_hi is not all copies of P_lo[WIDTH−1].
  - `data_result` = P_lo, even when an overflow is flagged.
- **Divide:**
  - DPRE converts both operands to magnitudes and records quotient sign = signA ^ signB.
  - DIV runs restoring division: subtract the divisor via the adder (B inverted, Cin=1) and take the quotient bit from the adder carry-out. Keep the difference if carry = 1, otherwise restore.
  - DFIX negates the quotient if the sign bit is set. The result truncates toward zero; the remainder is discarded.
  - Divisor = 0: detected on the start edge. Skip straight to DONE with result 0 and exception 1.
  - Dividend = −2^(WIDTH−1) with divisor = −1: result 0x80000000 and exception 1, at normal divide latency.
- **Reset values:** `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, state = IDLE, counter = 0.

## Timing
- E0 is the edge on which a start pulse is sampled.
- `data_resultRDY` rises after these edges:
  - Multiply: E(WIDTH+1) (E33 at default width).
  - Divide: E(WIDTH+2) (E34 at default width).
  - Divide-by-zero: E1.
- `data_resultRDY` is high for exactly one cycle. `data_result` and `data_exception` update on the same edge and stay stable until the next start.
- A restart at edge Ek suppresses any pending `data_resultRDY`. Latency is counted from Ek.
- `reset_n` low mid-operation clears everything immediately. No `data_resultRDY` follows until a new start.
- The single iteration path is one 32-bit CLA add followed by a register. Each iteration cycle issues exactly one add.

## Configuration
- `MULTDIV_DIV_EN` defined: full divider present, as described above.
- `MULTDIV_DIV_EN` undefined:
  - DPRE, DIV and DFIX are removed.
  - `ctrl_DIV` goes directly to DONE: `data_result` = 0, `data_exception` = 1, `data_resultRDY` at E1.
  - Multiply behaviour is unchanged.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state enum: IDLE, MUL, MFIN, DPRE, DIV, DFIX, DONE;
  - the Booth op encoding (NOP, ADD, SUB);
  - the MUL_LAT and DIV_LAT constants.
- Sub-module `cla_32`: WIDTH/8 existing `cla_8` slices joined by a second-level lookahead over their P/G outputs. It exposes the sum and carry-out. There is exactly one instance, shared by the multiply and divide paths.
- Everything else (FSM, counter, shift registers, sign logic) lives in `multdiv_seq`.

## Test plan
- `ctrl_MULT`, A=7, B=−3 → `data_result`=0xFFFFFFEB, exception 0, `data_resultRDY` only after E33.
- `ctrl_MULT`, A=0x00010000, B=0x00010000 → `data_result`=0x00000000, exception 1.
- `ctrl_DIV`, A=−100, B=7 → `data_result`=0xFFFFFFF2 (−14), exception 0, `data_resultRDY` after E34. Repeat with A=0x80000000, B=−1 → 0x80000000, exception 1.
- `ctrl_DIV`, A=5, B=0 → `data_result`=0, exception 1, `data_resultRDY` after E1. With `MULTDIV_DIV_EN` undefined, A=40, B=8 gives the same response.
- `ctrl_MULT` at E0, then `ctrl_DIV` A=40, B=8 at E10 → a single `data_resultRDY` after E44, `data_result`=5.
- `reset_n` low at E20 of a divide → all outputs 0 and no `data_resultRDY` over the following 40 cycles.
